// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction fields into MIPS words and writes them to imem
module instr_encoder_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);
   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       wdata_q, wdata_d, enc;
   logic [5:0]        opc;
   logic              last_q, last_d, err_q, err_d, legal;
   logic              ready_q, we_q, busy_q, done_q;
   // encode the presented fields; only opcodes the main decoder knows are legal
   always_comb begin
      legal = in_op <= 3'd5;
      opc   = in_op == 3'd1 ? 6'h23 : in_op == 3'd2 ? 6'h2b : in_op == 3'd3 ? 6'h04 : 6'h08;
      enc   = in_op == 3'd0 ? {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct} :
              in_op == 3'd5 ? {6'h02, in_target} : {opc, in_rs, in_rt, in_imm};
   end
   // next state: one word accepted, then written on the following cycle
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      last_d   = last_q;
      err_d    = err_q;
      case (state_q)
         IDLE: if (start) begin
            state_d  = ACCEPT;
            wr_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
         end
         ACCEPT: if (in_valid && ready_q) begin
            if (legal) begin
               state_d = WRITE;
               addr_d  = wr_ptr_q;
               wdata_d = enc;
               last_d  = in_last;
            end else begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         WRITE: begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + (ADDR_W + 1)'(1);
            state_d  = (last_q || wr_ptr_d == '0) ? DONE : ACCEPT;
            err_d    = err_q || (!last_q && wr_ptr_d == '0);
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered outputs, outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         last_q   <= last_d;
         err_q    <= err_d;
         ready_q  <= state_d == ACCEPT;
         we_q     <= state_d == WRITE;
         busy_q   <= state_d != IDLE;
         done_q   <= state_d == DONE;
      end
   end
   assign in_ready   = ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign count      = count_q;
endmodule
